bram_blocks_rr_sched: RTL and testbench



---
 rtl/bram_blocks_rr_sched.sv | 143 ++++++++++++++
 tb/tb_bram_blocks_rr_sched.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_blocks_rr_sched.sv
// Round-robin read scheduler and write serialiser in front of a dual-port block BRAM streamer.
// Every read or write pass covers all NUM_BLOCKS blocks, so the streamer address counters always end back at block 0.
`timescale 1ns/1ps

module bram_blocks_rr_sched #(
    parameter int REGISTER_SIZE = 32,
    parameter int NUM_BLOCKS    = 128,
    parameter int NUM_CLIENTS   = 2
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic [NUM_CLIENTS-1:0]   rd_req_in,
    output logic [NUM_CLIENTS-1:0]   rd_grant_out,
    output logic [REGISTER_SIZE-1:0] rd_block_out,
    output logic [NUM_CLIENTS-1:0]   rd_block_valid_out,
    output logic [NUM_CLIENTS-1:0]   rd_pass_done_out,
    input  logic                     wr_valid_in,
    input  logic [REGISTER_SIZE-1:0] wr_block_in,
    output logic                     wr_ready_out,
    output logic                     wr_pass_done_out,
    output logic                     bram_rst_out,
    output logic                     bram_read_next_out,
    output logic                     bram_write_next_out,
    output logic [REGISTER_SIZE-1:0] bram_write_block_out,
    input  logic [REGISTER_SIZE-1:0] bram_read_block_in,
    input  logic                     bram_read_valid_in
);

    localparam int CNT_W    = $clog2(NUM_BLOCKS) + 1;
    localparam int CLIENT_W = $clog2(NUM_CLIENTS);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] LAST_BLK  = CNT_W'(NUM_BLOCKS - 1);
    localparam logic [CNT_W-1:0] FULL_PASS = CNT_W'(NUM_BLOCKS);

    typedef enum logic [1:0] {IDLE, WRITE, RD_ISSUE, RD_DRAIN} state_t;

    state_t              state;
    logic [1:0]          rst_sync;
    logic [CNT_W-1:0]    wr_cnt;
    logic [CNT_W-1:0]    iss_cnt;
    logic [CNT_W-1:0]    ret_cnt;
    logic [CNT_W-1:0]    ret_next;
    logic [CLIENT_W-1:0] rr_ptr;
    logic [CLIENT_W-1:0] grant_idx;
    logic [CLIENT_W-1:0] pick_idx;
    logic                wr_accept;

    // First requester after ptr, searching ptr+1, ptr+2, ... modulo NUM_CLIENTS.
    function automatic logic [CLIENT_W-1:0] rr_pick(input logic [NUM_CLIENTS-1:0] req,
                                                    input logic [CLIENT_W-1:0]    ptr);
        logic [CLIENT_W-1:0] pick;
        int                  idx;
        pick = ptr;
        for (int i = NUM_CLIENTS; i >= 1; i--) begin
            idx = (int'(ptr) + i) % NUM_CLIENTS;
            if (req[idx]) pick = CLIENT_W'(idx);
        end
        return pick;
    endfunction

    // Streamer reset is held for two edges after release so its counters restart at block 0.
    assign bram_rst_out = ~rst_sync[1];

    // The write-done cycle is a one-cycle bubble: no new write, but reads may arbitrate.
    assign wr_ready_out = ~bram_rst_out & ~wr_pass_done_out &
                          ((state == IDLE) || (state == WRITE));
    assign wr_accept            = wr_valid_in & wr_ready_out;
    assign bram_write_next_out  = wr_accept;
    assign bram_write_block_out = wr_block_in;

    assign bram_read_next_out = (state == RD_ISSUE);
    assign rd_block_out       = bram_read_block_in;
    assign rd_block_valid_out = bram_read_valid_in ? rd_grant_out : '0;

    assign ret_next = ret_cnt + CNT_W'(bram_read_valid_in);
    assign pick_idx = rr_pick(rd_req_in, rr_ptr);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state            <= IDLE;
            rst_sync         <= 2'b00;
            wr_cnt           <= '0;
            iss_cnt          <= '0;
            ret_cnt          <= '0;
            rr_ptr           <= '0;
            grant_idx        <= '0;
            rd_grant_out     <= '0;
            rd_pass_done_out <= '0;
            wr_pass_done_out <= 1'b0;
        end else begin
            rst_sync         <= {rst_sync[0], 1'b1};
            wr_pass_done_out <= 1'b0;
            rd_pass_done_out <= '0;
            case (state)
                IDLE: begin
                    if (wr_accept) begin
                        wr_cnt <= CNT_ONE;
                        state  <= WRITE;
                    end else if (!bram_rst_out && (|rd_req_in)) begin
                        grant_idx    <= pick_idx;
                        rd_grant_out <= NUM_CLIENTS'(1) << pick_idx;
                        iss_cnt      <= '0;
                        ret_cnt      <= '0;
                        state        <= RD_ISSUE;
                    end
                end
                WRITE: begin
                    if (wr_accept) begin
                        if (wr_cnt == LAST_BLK) begin
                            wr_cnt           <= '0;
                            wr_pass_done_out <= 1'b1;
                            state            <= IDLE;
                        end else begin
                            wr_cnt <= wr_cnt + CNT_ONE;
                        end
                    end
                end
                RD_ISSUE: begin
                    ret_cnt <= ret_next;
                    if (iss_cnt == LAST_BLK) begin
                        iss_cnt <= '0;
                        state   <= RD_DRAIN;
                    end else begin
                        iss_cnt <= iss_cnt + CNT_ONE;
                    end
                end
                RD_DRAIN: begin
                    ret_cnt <= ret_next;
                    // Finish on the edge that accepts the last return, so done lands one cycle after it.
                    if (ret_next >= FULL_PASS) begin
                        rd_pass_done_out <= rd_grant_out;
                        rd_grant_out     <= '0;
                        rr_ptr           <= grant_idx;
                        ret_cnt          <= '0;
                        state            <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bram_blocks_rr_sched.sv
// Directed bench for bram_blocks_rr_sched with a behavioural two-cycle-latency BRAM streamer attached.
// Stimulus queues expected writes, read returns and done pulses; a negedge monitor pops and compares them.
`timescale 1ns/1ps

module tb_bram_blocks_rr_sched;

    localparam int RS = 32;
    localparam int NB = 4;
    localparam int NC = 2;

    logic          clk_in   = 1'b0;
    logic          rst_n_in = 1'b1;
    logic [NC-1:0] rd_req_in = '0;
    logic [NC-1:0] rd_grant_out;
    logic [RS-1:0] rd_block_out;
    logic [NC-1:0] rd_block_valid_out;
    logic [NC-1:0] rd_pass_done_out;
    logic          wr_valid_in = 1'b0;
    logic [RS-1:0] wr_block_in = '0;
    logic          wr_ready_out;
    logic          wr_pass_done_out;
    logic          bram_rst_out;
    logic          bram_read_next_out;
    logic          bram_write_next_out;
    logic [RS-1:0] bram_write_block_out;
    logic [RS-1:0] bram_read_block_in;
    logic          bram_read_valid_in;

    always #5 clk_in = ~clk_in;

    bram_blocks_rr_sched #(
        .REGISTER_SIZE(RS),
        .NUM_BLOCKS   (NB),
        .NUM_CLIENTS  (NC)
    ) dut (
        .clk_in              (clk_in),
        .rst_n_in            (rst_n_in),
        .rd_req_in           (rd_req_in),
        .rd_grant_out        (rd_grant_out),
        .rd_block_out        (rd_block_out),
        .rd_block_valid_out  (rd_block_valid_out),
        .rd_pass_done_out    (rd_pass_done_out),
        .wr_valid_in         (wr_valid_in),
        .wr_block_in         (wr_block_in),
        .wr_ready_out        (wr_ready_out),
        .wr_pass_done_out    (wr_pass_done_out),
        .bram_rst_out        (bram_rst_out),
        .bram_read_next_out  (bram_read_next_out),
        .bram_write_next_out (bram_write_next_out),
        .bram_write_block_out(bram_write_block_out),
        .bram_read_block_in  (bram_read_block_in),
        .bram_read_valid_in  (bram_read_valid_in)
    );

    // Streamer: auto-incrementing wrapped addresses, read data two cycles after the request.
    logic [RS-1:0] mem [NB];
    int unsigned   wa = 0;
    int unsigned   ra = 0;
    logic          v1 = 1'b0;
    logic          v2 = 1'b0;
    logic [RS-1:0] d1 = '0;
    logic [RS-1:0] d2 = '0;

    always @(posedge clk_in) begin
        if (bram_rst_out) begin
            wa <= 0;
            ra <= 0;
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else begin
            if (bram_write_next_out) begin
                mem[wa] <= bram_write_block_out;
                wa      <= (wa + 1) % NB;
            end
            v1 <= bram_read_next_out;
            if (bram_read_next_out) begin
                d1 <= mem[ra];
                ra <= (ra + 1) % NB;
            end
            v2 <= v1;
            d2 <= d1;
        end
    end

    assign bram_read_valid_in = v2;
    assign bram_read_block_in = d2;

    int n_checks = 0;
    int n_errs   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    logic [RS-1:0]    exp_wr_q[$];
    logic [NC+RS-1:0] exp_rd_q[$];
    logic [NC-1:0]    exp_done_q[$];
    bit               exp_wdone_q[$];

    int   cyc         = 0;
    int   issue_start = 0;
    int   run_len     = 0;
    bit   in_pass     = 1'b0;
    bit   first_valid = 1'b1;
    logic prev_rn     = 1'b0;

    always @(negedge clk_in) begin
        cyc++;
        if (!rst_n_in) begin
            in_pass     = 1'b0;
            run_len     = 0;
            prev_rn     = 1'b0;
            first_valid = 1'b1;
        end else begin
            chk("rd_wr_issue_overlap", bram_read_next_out & bram_write_next_out, 0);
            if (bram_read_next_out && !prev_rn) begin
                chk("issue_while_pass_open", in_pass, 0);
                chk("grant_onehot_at_issue", $onehot(rd_grant_out), 1);
                in_pass     = 1'b1;
                issue_start = cyc;
                run_len     = 0;
                first_valid = 1'b0;
            end
            if (bram_read_next_out) run_len++;
            if (!bram_read_next_out && prev_rn) chk("issue_run_length", run_len, NB);
            prev_rn = bram_read_next_out;
            if (rd_grant_out != 0) chk("wr_ready_during_read", wr_ready_out, 0);

            if (bram_write_next_out) begin
                chk("bram_write_expected", exp_wr_q.size() != 0, 1);
                if (exp_wr_q.size() != 0) chk("bram_write_data", bram_write_block_out, exp_wr_q.pop_front());
            end
            if (rd_block_valid_out != 0) begin
                if (!first_valid) begin
                    chk("first_valid_latency", cyc - issue_start, 2);
                    first_valid = 1'b1;
                end
                chk("rd_data_expected", exp_rd_q.size() != 0, 1);
                if (exp_rd_q.size() != 0)
                    chk("rd_strobe_and_data", {rd_block_valid_out, rd_block_out}, exp_rd_q.pop_front());
            end
            if (rd_pass_done_out != 0) begin
                chk("rd_done_latency", cyc - issue_start, NB + 2);
                chk("rd_done_expected", exp_done_q.size() != 0, 1);
                if (exp_done_q.size() != 0) chk("rd_done_mask", rd_pass_done_out, exp_done_q.pop_front());
                in_pass = 1'b0;
            end
            if (wr_pass_done_out) begin
                chk("wr_done_expected", exp_wdone_q.size() != 0, 1);
                if (exp_wdone_q.size() != 0) void'(exp_wdone_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Assert reset, check the async clear, release, and check the two-edge streamer reset window.
    task automatic do_reset();
        rst_n_in = 1'b0;
        #1;
        chk("rst_bram_rst_high", bram_rst_out, 1);
        chk("rst_grant_zero", rd_grant_out, 0);
        chk("rst_wr_ready_zero", wr_ready_out, 0);
        chk("rst_read_next_zero", bram_read_next_out, 0);
        chk("rst_rd_done_zero", rd_pass_done_out, 0);
        chk("rst_wr_done_zero", wr_pass_done_out, 0);
        repeat (2) tick();
        rst_n_in    = 1'b1;
        wr_valid_in = 1'b1;
        wr_block_in = 32'hEE;
        chk("release_wr_ready_zero", wr_ready_out, 0);
        tick();
        wr_valid_in = 1'b0;
        chk("edge1_bram_rst_high", bram_rst_out, 1);
        chk("edge1_wr_ready_zero", wr_ready_out, 0);
        chk("edge1_grant_zero", rd_grant_out, 0);
        tick();
        chk("edge2_bram_rst_low", bram_rst_out, 0);
        chk("edge2_wr_ready_high", wr_ready_out, 1);
        chk("edge2_grant_zero", rd_grant_out, 0);
    endtask

    task automatic wr_push(input logic [RS-1:0] d);
        chk("wr_ready_at_push", wr_ready_out, 1);
        exp_wr_q.push_back(d);
        wr_valid_in = 1'b1;
        wr_block_in = d;
        tick();
        wr_valid_in = 1'b0;
    endtask

    task automatic push_pass(input logic [NC-1:0] g, input logic [RS-1:0] base);
        for (int i = 0; i < NB; i++) exp_rd_q.push_back({g, base + RS'(i)});
        exp_done_q.push_back(g);
    endtask

    task automatic wait_done(input int budget = 100);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < budget && !seen; n++) begin
            @(negedge clk_in);
            seen = (rd_pass_done_out != 0);
        end
        chk("rd_done_within_budget", seen, 1);
    endtask

    initial begin
        #2;
        do_reset();

        // Write pass A0..A3 with a two-cycle gap after the second block.
        wr_push(32'hA0);
        wr_push(32'hA1);
        tick();
        tick();
        wr_push(32'hA2);
        exp_wdone_q.push_back(1'b1);
        wr_push(32'hA3);
        chk("wr_done_pulse", wr_pass_done_out, 1);
        chk("wr_ready_low_after_pass", wr_ready_out, 0);
        tick();
        chk("wr_done_single_cycle", wr_pass_done_out, 0);
        chk("wr_ready_back_in_idle", wr_ready_out, 1);

        // Client 0 alone; request dropped mid-pass must not abort it.
        push_pass(2'b01, 32'hA0);
        rd_req_in = 2'b01;
        tick();
        chk("c0_grant", rd_grant_out, 2'b01);
        chk("c0_issue_started", bram_read_next_out, 1);
        rd_req_in = 2'b00;
        wait_done();
        tick();
        chk("c0_grant_cleared", rd_grant_out, 0);

        // Both clients held: rr pointer is at client 0, so grants go 10, 01, 10.
        push_pass(2'b10, 32'hA0);
        push_pass(2'b01, 32'hA0);
        push_pass(2'b10, 32'hA0);
        rd_req_in = 2'b11;
        wait_done();
        wait_done();
        tick();
        chk("rr_third_grant", rd_grant_out, 2'b10);
        rd_req_in = 2'b00;
        wait_done();
        tick();

        // Reset during RD_ISSUE after two issues; both requesting through the reset.
        rd_req_in = 2'b01;
        tick();
        chk("abort_grant", rd_grant_out, 2'b01);
        tick();
        tick();
        chk("abort_still_issuing", bram_read_next_out, 1);
        rd_req_in = 2'b11;
        do_reset();
        push_pass(2'b10, 32'hA0);
        tick();
        chk("post_reset_rr_from_client0", rd_grant_out, 2'b10);
        rd_req_in = 2'b00;
        wait_done();
        tick();

        // Write and read request in the same IDLE cycle: write wins, read follows the write-done bubble.
        rd_req_in = 2'b01;
        wr_push(32'hB0);
        chk("write_wins_no_grant", rd_grant_out, 0);
        wr_push(32'hB1);
        wr_push(32'hB2);
        exp_wdone_q.push_back(1'b1);
        wr_push(32'hB3);
        chk("wr_done_before_read", wr_pass_done_out, 1);
        chk("no_grant_in_wr_done_cycle", rd_grant_out, 0);
        push_pass(2'b01, 32'hB0);
        tick();
        chk("read_after_write_grant", rd_grant_out, 2'b01);
        rd_req_in = 2'b00;
        wait_done();
        repeat (3) tick();

        chk("wr_queue_drained", exp_wr_q.size(), 0);
        chk("rd_queue_drained", exp_rd_q.size(), 0);
        chk("done_queue_drained", exp_done_q.size(), 0);
        chk("wdone_queue_drained", exp_wdone_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
